paddle_tracker: RTL
===================

Name: paddle_tracker

Overview:
- Sits directly downstream of the ultrasonic distance stage.
- Consumes the 8-bit distance and its one-cycle new-measurement flag, rejects bad samples and averages the rest.
- Maps the average linearly onto the paddle's vertical range and slew-limits the result.
- Drives the paddle Y position consumed by the game logic and reports loss of tracking.

Parameters:
- DIST_MIN, 5: lower clamp, cm
- DIST_MAX, 45: upper clamp, cm
- SCALE, 960: mapping multiplier, px per cm ×64
- Y_MAX, 600: max paddle Y in px, ≤1023
- AVG_LOG2, 2: log2 of averaging depth (4 samples)
- STEP_MAX, 4: max px moved per slew tick
- STEP_DIV, 65000: clock cycles per slew tick
- MISS_MAX, 4: consecutive invalid samples before LOST
- TIMEOUT_CYC, 13000000: cycles without flag before LOST

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on clk edge)
- distance  in  8  measured distance, cm; 255 = out of range
- flag  in  1  one-cycle pulse, distance holds new sample
- ypos  out  10  paddle Y, px
- ypos_valid  out  1  one-cycle pulse when ypos changes
- lost  out  1  high when no valid tracking

Behaviour:
- Reset values, applied when rst==0 at clk edge, including mid-operation:
  - ypos=Y_MAX/2, ypos_valid=0, lost=1, state IDLE
  - history, sum, miss_cnt, timeout counter, tick counter all 0
- Sample qualification on cycle T (flag==1):
  - distance==0 or distance==255 → invalid; miss_cnt increments, saturating at MISS_MAX; history untouched.
  - Otherwise → valid; d = clamp(distance, DIST_MIN, DIST_MAX); miss_cnt=0.
- History is a 2^AVG_LOG2 shift register with running sum, width 8+AVG_LOG2.
  - TRACK: sum ← sum + d − oldest; d shifted in.
  - IDLE/LOST: every entry preloaded with d; sum ← d<<AVG_LOG2 (no ramp from 0).
- Mapping pipeline:
  - T+1: avg = sum>>AVG_LOG2.
  - T+2: target = min(((avg−DIST_MIN)×SCALE)>>6, Y_MAX); product 24 bits, unsigned.
  - target is registered and updates only from valid samples.
- Slew:
  - Tick counter runs 0..STEP_DIV−1 continuously; tick asserted at wrap.
  - On a tick in TRACK: if ypos≠target, ypos moves toward target by min(|target−ypos|, STEP_MAX) and ypos_valid=1 for that cycle; else no change.
  - A tick coinciding with a target update uses the old target.
- Timeout counter: cleared by any flag (valid or invalid); saturates at TIMEOUT_CYC.
- FSM:
  - IDLE: lost=1; first valid sample → TRACK with preload.
  - TRACK: lost=0; → LOST when miss_cnt reaches MISS_MAX or timeout counter reaches TIMEOUT_CYC. lost rises the cycle after the triggering event.
  - LOST: lost=1; ypos frozen, no ticks applied; next valid sample → TRACK with preload, lost=0 the following cycle.
  - Simultaneous valid flag and timeout expiry: the flag wins and the FSM stays in TRACK.
- Total latency flag → target: 2 cycles; target → ypos: first tick after that.

Optional Feature:
- Macro PADDLE_INVERT_EN.
- Defined: target = Y_MAX − mapped value (near hand = bottom of screen).
- Undefined: target = mapped value.
- Reset centre and all other behaviour unchanged either way.

Test Plan:
- Bench parameters: STEP_DIV=4, TIMEOUT_CYC=1000; all others default.
- Reset released, flag with distance=45 → lost falls to 0; target=600 two cycles later; ypos ramps 300→304→…→600 in 75 ticks with 75 ypos_valid pulses, then stays static.
- Preloaded at 45 (sum=180), flag with distance=5 → sum=140, avg=35, target=450; ypos steps down by 4 per tick.
- In TRACK, four flags with distance=255 → lost=1 the cycle after the 4th; ypos frozen across later ticks. A following flag with distance=25 → preload, target=300, lost=0.
- In TRACK, no flag for 1000 cycles → lost=1; a flag with distance=255 at cycle 999 prevents it and restarts the timeout count.
- distance=2 → clamped to 5, target=0. distance=0 → counted as a miss, target unchanged. distance=60 → clamped to 45, target=600.
- rst driven low mid-ramp for one cycle → next cycle ypos=300, lost=1, ypos_valid=0, state IDLE; the following sample preloads the history.

Source files
------------

// File: rtl/paddle_tracker.sv
// rtl/paddle_tracker.sv - filters ultrasonic distance samples into a slew-limited paddle Y position
// Optional build macro PADDLE_INVERT_EN flips the mapping (near hand = bottom of screen).
module paddle_tracker #(
  parameter int DIST_MIN    = 5,
  parameter int DIST_MAX    = 45,
  parameter int SCALE       = 960,
  parameter int Y_MAX       = 600,
  parameter int AVG_LOG2    = 2,
  parameter int STEP_MAX    = 4,
  parameter int STEP_DIV    = 65000,
  parameter int MISS_MAX    = 4,
  parameter int TIMEOUT_CYC = 13000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] distance,
  input  logic       flag,
  output logic [9:0] ypos,
  output logic       ypos_valid,
  output logic       lost
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 8 + AVG_LOG2;
  localparam int MW    = $clog2(MISS_MAX + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam int KW    = $clog2(STEP_DIV + 1);

  typedef enum logic [1:0] {IDLE, TRACK, LOST} state_t;

  state_t        state, state_next;
  logic [7:0]    hist [DEPTH];
  logic [SW-1:0] sum;
  logic [MW-1:0] miss_cnt, miss_next;
  logic [TW-1:0] tmo_cnt;
  logic [KW-1:0] tick_cnt;
  logic          map_pending;
  logic [9:0]    target, target_new, mapped, delta, step;
  logic [7:0]    d_clamp, avg, avg_off;
  logic [23:0]   prod, scaled;
  logic          sample_ok, sample_miss, tmo_expire, tick;

  always_comb begin
    sample_miss = flag && (distance == 8'd0 || distance == 8'hFF);
    sample_ok   = flag && !sample_miss;
    if (distance < 8'(DIST_MIN))      d_clamp = 8'(DIST_MIN);
    else if (distance > 8'(DIST_MAX)) d_clamp = 8'(DIST_MAX);
    else                              d_clamp = distance;
    miss_next = miss_cnt;
    if (sample_ok)
      miss_next = '0;
    else if (sample_miss && miss_cnt != MW'(MISS_MAX))
      miss_next = miss_cnt + 1'b1;
    tmo_expire = !flag && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    tick       = (tick_cnt == KW'(STEP_DIV - 1));
  end

  // Mapping stage: sum registered at the sample edge, target registered one edge later.
  always_comb begin
    avg     = 8'(sum >> AVG_LOG2);
    avg_off = (avg > 8'(DIST_MIN)) ? avg - 8'(DIST_MIN) : 8'd0;
    prod    = 24'(avg_off) * 24'(SCALE);
    scaled  = prod >> 6;
    mapped  = (scaled > 24'(Y_MAX)) ? 10'(Y_MAX) : 10'(scaled);
`ifdef PADDLE_INVERT_EN
    target_new = 10'(Y_MAX) - mapped;
`else
    target_new = mapped;
`endif
  end

  always_comb begin
    delta = (target > ypos) ? target - ypos : ypos - target;
    step  = (delta > 10'(STEP_MAX)) ? 10'(STEP_MAX) : delta;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_ok) state_next = TRACK;
      TRACK:   if ((sample_miss && miss_next == MW'(MISS_MAX)) || tmo_expire) state_next = LOST;
      LOST:    if (sample_ok) state_next = TRACK;
      default: state_next = IDLE;
    endcase
  end

  assign lost = (state != TRACK);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      sum         <= '0;
      miss_cnt    <= '0;
      tmo_cnt     <= '0;
      tick_cnt    <= '0;
      map_pending <= 1'b0;
      target      <= 10'(Y_MAX / 2);
      ypos        <= 10'(Y_MAX / 2);
      ypos_valid  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= 8'd0;
    end else begin
      state       <= state_next;
      miss_cnt    <= miss_next;
      map_pending <= sample_ok;
      tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
      if (flag)
        tmo_cnt <= '0;
      else if (tmo_cnt != TW'(TIMEOUT_CYC))
        tmo_cnt <= tmo_cnt + 1'b1;
      // Slew reads the registered target, so a same-edge target update lands next tick.
      ypos_valid <= 1'b0;
      if (tick && state == TRACK && ypos != target) begin
        ypos       <= (target > ypos) ? ypos + step : ypos - step;
        ypos_valid <= 1'b1;
      end
      if (map_pending)
        target <= target_new;
      if (sample_ok) begin
        if (state == TRACK) begin
          for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
          hist[0] <= d_clamp;
          sum     <= sum + SW'(d_clamp) - SW'(hist[DEPTH-1]);
        end else begin
          for (int i = 0; i < DEPTH; i++) hist[i] <= d_clamp;
          sum <= SW'(d_clamp) << AVG_LOG2;
        end
      end
    end
  end
endmodule
